// File: rtl/ysyx_23060332_regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle write forwarding.
module ysyx_23060332_regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic                wr_conflict
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NWR-1:0]  we_eff;
  logic            conflict_c;

  // Write ports that actually commit (writes to a hardwired r0 are dropped)
  always_comb begin
    we_eff = '0;
    for (int w = 0; w < int'(NWR); w++) begin
      we_eff[w] = wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0));
    end
  end

  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < int'(NWR); i++) begin
      for (int j = i + 1; j < int'(NWR); j++) begin
        if (we_eff[i] && we_eff[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
          conflict_c = 1'b1;
        end
      end
    end
  end

  // Writes retire producers, a new issue re-marks, flush clears everything
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < int'(NWR); w++) begin
      if (we_eff[w]) begin
        busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && !((ZERO_REG != 0) && (iss_addr == '0))) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  // Ascending port loop: the highest-index port's assignment wins on collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        regs[r] <= '0;
      end
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int w = 0; w < int'(NWR); w++) begin
        if (we_eff[w]) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
      busy        <= busy_nxt;
      wr_conflict <= conflict_c;
    end
  end

  // Forwarding is suppressed under reset since those writes will not commit
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
      rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
      if ((BYPASS != 0) && !rst) begin
        for (int w = 0; w < int'(NWR); w++) begin
          if (we_eff[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            rd_busy[p]              = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[p*AW +: AW] == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_regfile_sb.sv
// Bench for ysyx_23060332_regfile_sb (default parameters): directed vector
// table for the scoreboard corner cases, then random traffic against a model.
module tb_ysyx_23060332_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;
  logic        wr_conflict;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_23060332_regfile_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .wr_conflict(wr_conflict)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iss;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] exp_d0, exp_d1;
    logic        exp_b0, exp_b1;
    logic        exp_cf;
  } vec_t;

  vec_t vecs[22];

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_cf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic drive(input logic r, input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic iss, input logic [4:0] ia,
                       input logic fl, input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    iss_en = iss; iss_addr = ia; flush = fl; rd_addr = {ra1, ra0};
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1, input logic iss, input logic [4:0] ia,
                              input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] d0, input logic b0, input logic [31:0] d1, input logic b1,
                              input logic cf);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iss = iss; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.exp_d0 = d0; v.exp_b0 = b0; v.exp_d1 = d1; v.exp_b1 = b1; v.exp_cf = cf;
    return v;
  endfunction

  // Specification-level expected read: forwarded value from highest matching port, r0 is zero
  function automatic logic [32:0] model_read(input logic [4:0] a, input logic [1:0] we,
                                             input logic [4:0] wa0, input logic [4:0] wa1,
                                             input logic [31:0] wd0, input logic [31:0] wd1);
    logic [31:0] d;
    logic        b;
    d = m_regs[a];
    b = m_busy[a];
    if (we[1] && wa1 == a)      begin d = wd1; b = 1'b0; end
    else if (we[0] && wa0 == a) begin d = wd0; b = 1'b0; end
    if (a == 5'd0) begin d = '0; b = 1'b0; end
    return {b, d};
  endfunction

  initial begin
    // rst, we, wa0, wd0, wa1, wd1, iss, ia, fl, ra0, ra1, exp d0, b0, d1, b1, cf
    vecs[0]  = mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0,  0, 5, 0,  32'hDEADBEEF, 0, 0, 0, 0);
    vecs[1]  = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 5, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(0, 2'b01, 0, 32'h1234,     0, 0,     1, 0,  0, 0, 5,  0, 0, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 0, 5,  0, 0, 32'hDEADBEEF, 0, 0);
    vecs[4]  = mk(0, 2'b11, 7, 32'h11,       7, 32'h22, 0, 0, 0, 7, 0,  32'h22, 0, 0, 0, 0);
    vecs[5]  = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 7, 0,  32'h22, 0, 0, 0, 1);
    vecs[6]  = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 7, 0,  32'h22, 0, 0, 0, 0);
    vecs[7]  = mk(0, 2'b00, 0, 0,            0, 0,     1, 3,  0, 3, 7,  0, 0, 32'h22, 0, 0);
    vecs[8]  = mk(0, 2'b01, 3, 32'h55,       0, 0,     1, 3,  0, 3, 3,  32'h55, 0, 32'h55, 0, 0);
    vecs[9]  = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 3, 7,  32'h55, 1, 32'h22, 0, 0);
    vecs[10] = mk(0, 2'b10, 0, 0,            3, 32'h66, 0, 0, 0, 3, 9,  32'h66, 0, 0, 0, 0);
    vecs[11] = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 3, 9,  32'h66, 0, 0, 0, 0);
    vecs[12] = mk(0, 2'b00, 0, 0,            0, 0,     1, 9,  0, 9, 10, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 2'b00, 0, 0,            0, 0,     1, 10, 0, 9, 10, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, 2'b00, 0, 0,            0, 0,     1, 11, 1, 9, 10, 0, 1, 0, 1, 0);
    vecs[15] = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 9, 11, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 2'b01, 4, 32'h99,       0, 0,     1, 6,  0, 5, 7,  32'hDEADBEEF, 0, 32'h22, 0, 0);
    vecs[17] = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 4, 5,  0, 0, 0, 0, 0);
    vecs[18] = mk(0, 2'b01, 4, 32'h77,       0, 0,     0, 0,  0, 4, 6,  32'h77, 0, 0, 0, 0);
    vecs[19] = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 4, 6,  32'h77, 0, 0, 0, 0);
    vecs[20] = mk(0, 2'b11, 0, 32'hAA,       0, 32'hBB, 0, 0, 0, 4, 0,  32'h77, 0, 0, 0, 0);
    vecs[21] = mk(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 4, 0,  32'h77, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_wr_conflict", 32'(wr_conflict), 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      check("reset_rd_data0", rd_data[31:0], 32'd0);
      check("reset_rd_data1", rd_data[63:32], 32'd0);
      check("reset_rd_busy", 32'(rd_busy), 32'd0);
    end

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].iss, vecs[i].ia, vecs[i].fl, vecs[i].ra0, vecs[i].ra1);
      #1;
      check($sformatf("vec%0d_rd_data0", i), rd_data[31:0], vecs[i].exp_d0);
      check($sformatf("vec%0d_rd_data1", i), rd_data[63:32], vecs[i].exp_d1);
      check($sformatf("vec%0d_rd_busy0", i), 32'(rd_busy[0]), 32'(vecs[i].exp_b0));
      check($sformatf("vec%0d_rd_busy1", i), 32'(rd_busy[1]), 32'(vecs[i].exp_b1));
      check($sformatf("vec%0d_wr_conflict", i), 32'(wr_conflict), 32'(vecs[i].exp_cf));
    end

    // Random phase: start from a known reset so the model matches
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
    m_cf   = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        r, iss, fl;
      logic [1:0]  we;
      logic [4:0]  wa0, wa1, ia, ra0, ra1;
      logic [31:0] wd0, wd1;
      logic [32:0] e0, e1;
      r   = ($urandom_range(0, 49) == 0);
      we  = r ? 2'b00 : 2'($urandom);
      wa0 = 5'($urandom_range(0, 7));
      wa1 = 5'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      iss = ($urandom_range(0, 2) == 0);
      ia  = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 19) == 0);
      ra0 = 5'($urandom_range(0, 8));
      ra1 = 5'($urandom_range(0, 8));
      @(negedge clk);
      drive(r, we, wa0, wa1, wd0, wd1, iss, ia, fl, ra0, ra1);
      #1;
      e0 = model_read(ra0, we, wa0, wa1, wd0, wd1);
      e1 = model_read(ra1, we, wa0, wa1, wd0, wd1);
      check("rand_rd_data0", rd_data[31:0], e0[31:0]);
      check("rand_rd_data1", rd_data[63:32], e1[31:0]);
      check("rand_rd_busy0", 32'(rd_busy[0]), 32'(e0[32]));
      check("rand_rd_busy1", 32'(rd_busy[1]), 32'(e1[32]));
      check("rand_wr_conflict", 32'(wr_conflict), 32'(m_cf));
      if (r) begin
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        m_busy = '0;
        m_cf   = 1'b0;
      end else begin
        if (we[0] && wa0 != 0) begin m_regs[wa0] = wd0; m_busy[wa0] = 1'b0; end
        if (we[1] && wa1 != 0) begin m_regs[wa1] = wd1; m_busy[wa1] = 1'b0; end
        m_cf = we[0] && we[1] && wa0 == wa1 && wa0 != 0;
        if (iss && ia != 0) m_busy[ia] = 1'b1;
        if (fl) m_busy = '0;
      end
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
